vector_mem_unit: RTL and testbench

Memory-stage access unit between the SIMD pipeline's M stage and a single-port, 32-bit-wide synchronous data RAM. Scalar loads and stores pass through in one cycle. A 256-bit vector load or store is serialized into 8 word beats, and `stall` freezes the pipeline until the burst finishes. Its outputs produce the pipeline's `readdataM` and `Vmemout`, and it consumes `aluoutM`, `writedataM`, `memwriteM`, `src_sel` and `ValuoutM`.

---
 rtl/vmem_pkg.sv | 16 +
 rtl/vmem_lane_buffer.sv | 35 +++
 rtl/vector_mem_unit.sv | 143 ++++++++++++++
 tb/tb_vector_mem_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_pkg.sv
// Shared types and constants for the vector memory-stage unit.
// Word, vector and beat-counter widths plus the burst FSM state encoding.
package vmem_pkg;
  localparam int WORD_W    = 32;
  localparam int VEC_W     = 256;
  localparam int LANES_DEF = VEC_W / WORD_W;
  localparam int BEAT_W    = $clog2(LANES_DEF);

  typedef enum logic [2:0] {
    IDLE,
    LD_BURST,
    LD_DRAIN,
    ST_BURST,
    DONE
  } vmem_state_t;
endpackage

// File: rtl/vmem_lane_buffer.sv
// Vector load assembly register: one 32-bit lane written per returned beat,
// indexed by the beat number issued in the previous cycle.
module vmem_lane_buffer
  import vmem_pkg::*;
#(
  parameter int LANES = 8,
  parameter int CNT_W = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we,
  input  logic [CNT_W-1:0]          lane,
  input  logic [WORD_W-1:0]         wdata,
  output logic [LANES*WORD_W-1:0]   q
);

  logic [WORD_W-1:0] lane_q [LANES];

  // NOTE: this array is cleared on reset because vrdata has a defined reset
  // value; plain RAM arrays elsewhere should not be reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
    end else if (we) begin
      lane_q[lane] <= wdata;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_flat
    assign q[g*WORD_W +: WORD_W] = lane_q[g];
  end

endmodule

// File: rtl/vector_mem_unit.sv
// M-stage access unit: scalar pass-through and 8-beat serialized vector bursts.
// Optional VMEM_ALIGN_CHECK_EN adds a sticky misalign flag and suppresses misaligned requests.
module vector_mem_unit
  import vmem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LANES  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic                     memwrite,
  input  logic                     src_sel,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  input  logic [LANES*WORD_W-1:0]  vwdata,
  output logic [31:0]              rdata,
  output logic [LANES*WORD_W-1:0]  vrdata,
  output logic                     stall,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_we,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata
`ifdef VMEM_ALIGN_CHECK_EN
  ,
  output logic                     misalign
`endif
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

  vmem_state_t       state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [ADDR_W-1:0] base, base_q;
  logic              issue_ld, ld_valid_q;
  logic [CNT_W-1:0]  issue_beat, ld_beat_q;
  logic              blocked;
  logic [WORD_W-1:0] vw_lane [LANES];
  logic              unused_addr;

  assign base        = addr[ADDR_W+1:2];
  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};
  assign rdata       = mem_rdata;

  for (genvar g = 0; g < LANES; g++) begin : g_vw
    assign vw_lane[g] = vwdata[g*WORD_W +: WORD_W];
  end

`ifdef VMEM_ALIGN_CHECK_EN
  assign blocked = req_valid && (addr[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        misalign <= 1'b0;
    else if (state == IDLE && blocked) misalign <= 1'b1;
  end
`else
  assign blocked = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    mem_addr   = base;
    mem_we     = 1'b0;
    mem_wdata  = wdata;
    stall      = 1'b0;
    issue_ld   = 1'b0;
    issue_beat = cnt;
    unique case (state)
      IDLE: begin
        if (req_valid && !blocked) begin
          if (src_sel) begin
            // Beat 0 goes out directly from the live address this cycle.
            stall      = 1'b1;
            mem_we     = memwrite;
            mem_wdata  = vw_lane[0];
            issue_ld   = !memwrite;
            issue_beat = '0;
            cnt_nx     = CNT_W'(1);
            state_nx   = memwrite ? ST_BURST : LD_BURST;
          end else begin
            mem_we = memwrite;
          end
        end
      end
      LD_BURST, ST_BURST: begin
        stall     = 1'b1;
        mem_addr  = base_q + ADDR_W'(cnt);
        mem_we    = (state == ST_BURST);
        mem_wdata = vw_lane[cnt];
        issue_ld  = (state == LD_BURST);
        cnt_nx    = cnt + CNT_W'(1);
        if (cnt == LAST) begin
          cnt_nx   = '0;
          state_nx = (state == ST_BURST) ? DONE : LD_DRAIN;
        end
      end
      LD_DRAIN: begin
        stall    = 1'b1;
        state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Abandon the burst within the reset cycle itself, not at the next edge.
    if (reset) begin
      mem_we = 1'b0;
      stall  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      base_q     <= '0;
      ld_valid_q <= 1'b0;
      ld_beat_q  <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      ld_valid_q <= issue_ld;
      ld_beat_q  <= issue_beat;
      if (state == IDLE && state_nx != IDLE) base_q <= base;
    end
  end

  vmem_lane_buffer #(
    .LANES (LANES),
    .CNT_W (CNT_W)
  ) u_lane_buffer (
    .clk   (clk),
    .reset (reset),
    .we    (ld_valid_q),
    .lane  (ld_beat_q),
    .wdata (mem_rdata),
    .q     (vrdata)
  );

endmodule

// File: tb/tb_vector_mem_unit.sv
// Directed bench for vector_mem_unit with a behavioural synchronous RAM.
// Optional VMEM_ALIGN_CHECK_EN enables the misalignment scenario.
module tb_vector_mem_unit;

  logic         clk = 1'b0;
  logic         reset, req_valid, memwrite, src_sel;
  logic [31:0]  addr, wdata, rdata, mem_wdata, mem_rdata;
  logic [255:0] vwdata, vrdata;
  logic         stall, mem_we;
  logic [15:0]  mem_addr;
`ifdef VMEM_ALIGN_CHECK_EN
  logic         misalign;
`endif

  logic [31:0] ram [0:65535];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  vector_mem_unit #(.ADDR_W(16), .LANES(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .memwrite  (memwrite),
    .src_sel   (src_sel),
    .addr      (addr),
    .wdata     (wdata),
    .vwdata    (vwdata),
    .rdata     (rdata),
    .vrdata    (vrdata),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef VMEM_ALIGN_CHECK_EN
    ,
    .misalign  (misalign)
`endif
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    src_sel   = 1'b0;
    memwrite  = 1'b0;
    addr      = '0;
    wdata     = '0;
    vwdata    = '0;
  endtask

  function automatic logic [255:0] make_vec(input logic [31:0] seed);
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = seed + 32'(k);
    return v;
  endfunction

  task automatic scalar_store(input logic [31:0] a, input logic [31:0] d);
    next_cycle();
    req_valid = 1'b1;
    src_sel   = 1'b0;
    memwrite  = 1'b1;
    addr      = a;
    wdata     = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b expected 0", stall); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we got %b expected 0", mem_we); end
    n_cmp++; if (vrdata !== 256'd0) begin n_bad++; $display("FAIL reset_vrdata got %h expected 0", vrdata); end
`ifdef VMEM_ALIGN_CHECK_EN
    n_cmp++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL reset_misalign got %b expected 0", misalign); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_scalar();
    scalar_store(32'h10, 32'hDEADBEEF);
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL sc_st_we got %b expected 1", mem_we); end
    n_cmp++; if (mem_addr !== 16'd4) begin n_bad++; $display("FAIL sc_st_addr got %0d expected 4", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sc_st_wdata got %h expected deadbeef", mem_wdata); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL sc_st_stall got %b expected 0", stall); end
    next_cycle();
    memwrite = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL sc_ld_we got %b expected 0", mem_we); end
    n_cmp++; if (mem_addr !== 16'd4) begin n_bad++; $display("FAIL sc_ld_addr got %0d expected 4", mem_addr); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL sc_ld_stall got %b expected 0", stall); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sc_ld_rdata got %h expected deadbeef", rdata); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL sc_w_stall got %b expected 0", stall); end
  endtask

  task automatic test_vector_store();
    int stall_cnt = 0;
    next_cycle();
    req_valid = 1'b1; src_sel = 1'b1; memwrite = 1'b1;
    addr = 32'h40; vwdata = make_vec(32'h1000);
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (c < 8) begin
        n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL vst_we c=%0d got %b expected 1", c, mem_we); end
        n_cmp++; if (mem_addr !== 16'(16 + c)) begin n_bad++; $display("FAIL vst_addr c=%0d got %0d expected %0d", c, mem_addr, 16 + c); end
        n_cmp++; if (mem_wdata !== 32'h1000 + 32'(c)) begin n_bad++; $display("FAIL vst_wdata c=%0d got %h expected %h", c, mem_wdata, 32'h1000 + 32'(c)); end
        next_cycle();
      end else begin
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL vst_done_we got %b expected 0", mem_we); end
      end
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (stall_cnt != 8) begin n_bad++; $display("FAIL vst_stall_cycles got %0d expected 8", stall_cnt); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (ram[16 + k] !== 32'h1000 + 32'(k)) begin n_bad++; $display("FAIL vst_ram word=%0d got %h expected %h", 16 + k, ram[16 + k], 32'h1000 + 32'(k)); end
    end
  endtask

  task automatic test_vector_load(input logic [31:0] a, input logic [15:0] b,
                                  input logic [255:0] exp, input string tag);
    int stall_cnt = 0;
    next_cycle();
    req_valid = 1'b1; src_sel = 1'b1; memwrite = 1'b0; addr = a;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (c < 8) begin
        n_cmp++; if (mem_addr !== 16'(b + 16'(c))) begin n_bad++; $display("FAIL %s_addr c=%0d got %0d expected %0d", tag, c, mem_addr, 16'(b + 16'(c))); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL %s_we c=%0d got %b expected 0", tag, c, mem_we); end
      end
      if (c == 9) begin
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL %s_done_stall got %b expected 0", tag, stall); end
        n_cmp++; if (vrdata !== exp) begin n_bad++; $display("FAIL %s_vrdata got %h expected %h", tag, vrdata, exp); end
      end else begin
        next_cycle();
      end
    end
    next_cycle();
    idle_inputs();
    n_cmp++; if (stall_cnt != 9) begin n_bad++; $display("FAIL %s_stall_cycles got %0d expected 9", tag, stall_cnt); end
  endtask

  task automatic test_wrap();
    logic [255:0] exp;
    for (int k = 0; k < 8; k++) begin
      scalar_store({14'd0, 16'(16'd65533 + 16'(k)), 2'b00}, 32'hA000 + 32'(k));
      exp[k*32 +: 32] = 32'hA000 + 32'(k);
    end
    test_vector_load(32'h0003FFF4, 16'd65533, exp, "wrap");
  endtask

  task automatic test_reset_mid_burst();
    scalar_store(32'h90, 32'h55555555);
    next_cycle();
    req_valid = 1'b1; src_sel = 1'b1; memwrite = 1'b1;
    addr = 32'h80; vwdata = make_vec(32'h2000);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL rst_pre_we c=%0d got %b expected 1", c, mem_we); end
      next_cycle();
    end
    reset = 1'b1;
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mid_we got %b expected 0", mem_we); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_mid_stall got %b expected 0", stall); end
    @(negedge clk);
    n_cmp++; if (vrdata !== 256'd0) begin n_bad++; $display("FAIL rst_mid_vrdata got %h expected 0", vrdata); end
    reset = 1'b0;
    idle_inputs();
    next_cycle();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (ram[32 + k] !== 32'h2000 + 32'(k)) begin n_bad++; $display("FAIL rst_ram word=%0d got %h expected %h", 32 + k, ram[32 + k], 32'h2000 + 32'(k)); end
    end
    n_cmp++; if (ram[36] !== 32'h55555555) begin n_bad++; $display("FAIL rst_ram_untouched got %h expected 55555555", ram[36]); end
    test_vector_load(32'h40, 16'd16, make_vec(32'h1000), "postrst");
  endtask

  task automatic test_back_to_back();
    next_cycle();
    req_valid = 1'b1; src_sel = 1'b1; memwrite = 1'b0; addr = 32'h40;
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      if (c < 8) begin
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL b2b_ld_we c=%0d got %b expected 0", c, mem_we); end
        n_cmp++; if (mem_addr !== 16'(16 + c)) begin n_bad++; $display("FAIL b2b_ld_addr c=%0d got %0d expected %0d", c, mem_addr, 16 + c); end
      end else if (c == 8) begin
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL b2b_drain_stall got %b expected 1", stall); end
      end else if (c == 9) begin
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_done_stall got %b expected 0", stall); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL b2b_done_we got %b expected 0", mem_we); end
        n_cmp++; if (vrdata !== make_vec(32'h1000)) begin n_bad++; $display("FAIL b2b_vrdata got %h expected %h", vrdata, make_vec(32'h1000)); end
      end else if (c < 18) begin
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL b2b_st_stall c=%0d got %b expected 1", c, stall); end
        n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL b2b_st_we c=%0d got %b expected 1", c, mem_we); end
        n_cmp++; if (mem_addr !== 16'(48 + c - 10)) begin n_bad++; $display("FAIL b2b_st_addr c=%0d got %0d expected %0d", c, mem_addr, 48 + c - 10); end
        n_cmp++; if (mem_wdata !== 32'h3000 + 32'(c - 10)) begin n_bad++; $display("FAIL b2b_st_wdata c=%0d got %h expected %h", c, mem_wdata, 32'h3000 + 32'(c - 10)); end
      end else begin
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_st_done_stall got %b expected 0", stall); end
      end
      if (c < 18) begin
        next_cycle();
        if (c == 3) begin
          // Next instruction appears mid-burst; the active load must ignore it.
          memwrite = 1'b1; addr = 32'hC0; vwdata = make_vec(32'h3000);
        end
      end
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (ram[48] !== 32'h3000 || ram[55] !== 32'h3007) begin n_bad++; $display("FAIL b2b_ram got %h/%h expected 3000/3007", ram[48], ram[55]); end
  endtask

`ifdef VMEM_ALIGN_CHECK_EN
  task automatic test_align();
    next_cycle();
    req_valid = 1'b1; src_sel = 1'b1; memwrite = 1'b0; addr = 32'h42;
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL al_stall got %b expected 0", stall); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL al_we got %b expected 0", mem_we); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (misalign !== 1'b1) begin n_bad++; $display("FAIL al_flag got %b expected 1", misalign); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL al_stall2 got %b expected 0", stall); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (misalign !== 1'b1) begin n_bad++; $display("FAIL al_sticky got %b expected 1", misalign); end
  endtask
`endif

  initial begin
    test_reset();
    test_scalar();
    test_vector_store();
    test_vector_load(32'h40, 16'd16, make_vec(32'h1000), "vld");
    test_wrap();
    test_reset_mid_burst();
    test_back_to_back();
`ifdef VMEM_ALIGN_CHECK_EN
    test_align();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
